regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single regfile write port (we3/wa3/wd3) between the execute-stage writeback (requester 0, stallable) and the memory-stage load return (requester 1, non-stallable). Load returns are buffered in a small FIFO, contended grants alternate round-robin, and writes to xzr (x31) are consumed without a write. The output stage is registered and connects directly to the regfile write port.

## Interface
- DATA_W, 64, write data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, requester-1 buffer entries (power of two, ≥2)

- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- v0  in  1  requester 0 valid
- a0  in  ADDR_W  requester 0 destination register
- d0  in  DATA_W  requester 0 data
- ready0  out  1  requester 0 accepted this cycle (combinational)
- v1  in  1  requester 1 valid; pushed into the FIFO unconditionally
- a1  in  ADDR_W  requester 1 destination register
- d1  in  DATA_W  requester 1 data
- ovf  out  1  sticky: requester 1 push was lost because the FIFO was full
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- we3  out  1  regfile write enable (registered)
- wa3  out  ADDR_W  regfile write address (registered)
- wd3  out  DATA_W  regfile write data (registered)

## Operation
- Sources each cycle: S0 = requester 0 (v0), S1 = FIFO head (fifo_count>0). No bypass: a v1 push is visible as S1 only in the next cycle.
- Arbitration when exactly one source is pending: that source is granted.
- Arbitration when both are pending:
  - If a0 equals the head address and the address is not 31, S1 is granted (older instruction first). The round-robin pointer is unchanged.
  - Otherwise the source the pointer names is granted, and the pointer flips to the other source.
- Round-robin pointer reset value: S0.
- ready0 = v0 & granted(S0). ready0 is 0 while reset is asserted.
- A grant of S1 pops the FIFO head.
- Effect of a grant on the output stage:
  - Granted address ≠ 31: we3<=1, wa3<=addr, wd3<=data.
  - Granted address = 31: the request is consumed, we3<=0, and wa3/wd3 hold.
  - No grant: we3<=0, and wa3/wd3 hold.
- FIFO behaviour:
  - A push and a pop in the same cycle when full is legal: count stays FIFO_DEPTH and ovf is not set.
  - A push when full with no pop: the data is dropped and ovf<=1.
  - ovf clears only on reset.
- Reset values: we3=0, wa3=0, wd3=0, ovf=0, fifo_count=0, FIFO pointers 0, round-robin pointer → S0.
- Reset asserted mid-operation discards the FIFO contents and any pending output write immediately (asynchronous). we3 falls without waiting for a clock edge.

## Timing
- Requester 0: granted at edge N → we3/wa3/wd3 valid in cycle N..N+1 → regfile updated at edge N+1. Latency is 1 cycle from acceptance.
- Requester 1: pushed at edge N → earliest grant at edge N+1 → regfile updated at edge N+2. Minimum latency is 2 cycles.
- Throughput: at most one write per cycle. Sustained v1 every cycle with v0 constantly high overflows after FIFO_DEPTH+1 contended cycles, unless same-address priority drains the FIFO.
- ready0 depends combinationally on v0, a0 and the FIFO head only. It has no path from we3/wa3/wd3.
- Requester 0 holds v0/a0/d0 stable until ready0=1.

## Structure
- Package wb_pkg:
  - typedef wb_req_t {addr, data}
  - localparam XZR = 5'd31
  - enum src_t {SRC0, SRC1} for the round-robin pointer and grant
- Sub-module wb_fifo: parameterised FIFO_DEPTH × wb_req_t.
  - Ports: push, pop, head, count, full, overflow.
  - Pointer wrap at FIFO_DEPTH.
- Top level: arbiter logic, the round-robin pointer flop, and the output register.

## Test plan
- Reset, then v0=1 a0=5 d0=0xAA for one cycle → ready0=1 in that cycle. The following cycle shows we3=1 wa3=5 wd3=0xAA, and a subsequent regfile read of x5 = 0xAA.
- v1 a1=7 d1=0x11 with v0 idle → fifo_count=1 after the push edge. The next cycle shows we3=1 wa3=7, and count returns to 0.
- FIFO head (a=3) and v0 (a0=4) contend for 4 cycles with refills → grants alternate S0,S1,S0,S1. ready0 toggles 1,0,1,0.
- FIFO head a=9 d=0x22 and v0 a0=9 d0=0x33 contend → S1 is granted first and ready0=0. x9 ends at 0x33, and the round-robin pointer is unchanged.
- v0 a0=31 d0=0xC0C0 → ready0=1 and we3 stays 0. A regfile read of x31 returns 0.
- v0 held high while v1 pushes 4 consecutive cycles (a1=1..4) with FIFO_DEPTH=2 → ovf=1 and exactly one push is lost. Then assert reset mid-stream → ovf=0, fifo_count=0 and we3=0 without a clock edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
// Both requesters and the load-return buffer carry a request as {addr, data}.
package wb_pkg;

    localparam int WB_DATA_W = 64;
    localparam int WB_ADDR_W = 5;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_t;

    function automatic src_t src_flip(input src_t s);
        src_t r;
        case (s)
            SRC0:    r = SRC1;
            SRC1:    r = SRC0;
            default: r = SRC0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Request-side bundle of the writeback arbiter: execute-stage writeback
// (requester 0, stallable) and memory-stage load return (requester 1).
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              v0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              ready0;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;

    modport master (
        output v0, a0, d0, v1, a1, d1,
        input  ready0
    );

    modport slave (
        input  v0, a0, d0, v1, a1, d1,
        output ready0
    );
endinterface

// File: rtl/wb_fifo.sv
// Small circular buffer for load returns. A push into a full buffer is dropped
// unless the head is popped in the same cycle; a dropped push sets a sticky flag.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  FIFO_DEPTH = 2,
    parameter type entry_t    = wb_req_t
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  entry_t                        push_data,
    input  logic                          pop,
    output entry_t                        head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               ovf_r;
    logic               do_push_s;
    logic               do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Full is judged on the current occupancy; a simultaneous pop frees the slot.
    always_comb begin
        full      = (count_r == CNT_W'(FIFO_DEPTH));
        do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
        do_push_s = push && (!full || do_pop_s);
    end

    // Storage array.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (push && full && !do_pop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign head     = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign overflow = ovf_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single regfile write port between execute writeback (stallable)
// and buffered load returns; writes to xzr are consumed without a write strobe.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    regfile_wb_arbiter_if.slave           req,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          we3,
    output logic [ADDR_W-1:0]             wa3,
    output logic [DATA_W-1:0]             wd3
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] XZR_ADDR = ADDR_W'(XZR);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              head_s;
    req_t              push_req_s;
    req_t              grant_req_s;
    logic [CNT_W-1:0]  count_s;
    logic              full_s;
    logic              ovf_s;
    logic              s1_pending_s;
    logic              same_addr_s;
    logic              grant_valid_s;
    logic              pop_s;
    src_t              grant_src_s;
    src_t              rr_r;
    src_t              rr_next_s;

    assign push_req_s = '{addr: req.a1, data: req.d1};

    wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (req_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req.v1),
        .push_data (push_req_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .overflow  (ovf_s)
    );

    // Arbitration: same-address contention lets the older load win without
    // disturbing the round-robin pointer; other contention follows the pointer.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_src_s   = SRC0;
        rr_next_s     = rr_r;
        s1_pending_s  = full_s || (count_s != {CNT_W{1'b0}});
        same_addr_s   = (req.a0 == head_s.addr) && (req.a0 != XZR_ADDR);
        if (req.v0 && s1_pending_s) begin
            grant_valid_s = 1'b1;
            if (same_addr_s) begin
                grant_src_s = SRC1;
            end else begin
                grant_src_s = rr_r;
                rr_next_s   = src_flip(rr_r);
            end
        end else if (req.v0) begin
            grant_valid_s = 1'b1;
            grant_src_s   = SRC0;
        end else if (s1_pending_s) begin
            grant_valid_s = 1'b1;
            grant_src_s   = SRC1;
        end else begin
            grant_valid_s = 1'b0;
        end
    end

    // Select the winning request.
    always_comb begin
        grant_req_s = '{addr: req.a0, data: req.d0};
        case (grant_src_s)
            SRC0:    grant_req_s = '{addr: req.a0, data: req.d0};
            SRC1:    grant_req_s = head_s;
            default: grant_req_s = '{addr: req.a0, data: req.d0};
        endcase
    end

    assign req.ready0 = reset & req.v0 & grant_valid_s & (grant_src_s == SRC0);
    assign pop_s      = grant_valid_s & (grant_src_s == SRC1);

    // Round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_r <= SRC0;
        end else begin
            rr_r <= rr_next_s;
        end
    end

    // Registered regfile write port; address and data hold when nothing is written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we3 <= 1'b0;
            wa3 <= {ADDR_W{1'b0}};
            wd3 <= {DATA_W{1'b0}};
        end else if (grant_valid_s && (grant_req_s.addr != XZR_ADDR)) begin
            we3 <= 1'b1;
            wa3 <= grant_req_s.addr;
            wd3 <= grant_req_s.data;
        end else begin
            we3 <= 1'b0;
        end
    end

    assign ovf        = ovf_s;
    assign fifo_count = count_s;

endmodule
